// File: rtl/fifo_adc_burst_if.sv
// Sample bus between the ADC capture front-end and the burst FIFO.
// The master drives write/read/clear requests; the slave (FIFO) returns data and status.
interface fifo_adc_burst_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 128
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] adc_data_in;
  logic                  rd_en;
  logic                  clr_ovf;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  burst_ready;
  logic                  overflow;
  logic [15:0]           drop_count;

  modport master (
    output wr_en, adc_data_in, rd_en, clr_ovf,
    input  data_out, data_valid, level, full, empty,
           almost_full, burst_ready, overflow, drop_count
  );

  modport slave (
    input  wr_en, adc_data_in, rd_en, clr_ovf,
    output data_out, data_valid, level, full, empty,
           almost_full, burst_ready, overflow, drop_count
  );
endinterface

// File: rtl/fifo_adc_burst.sv
// Synchronous ADC sample FIFO with exact occupancy, burst/almost-full flags
// and a saturating counter of writes dropped while full.
module fifo_adc_burst #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 128,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned AF_LEVEL   = 96
) (
  input logic             clk,
  input logic             reset,
  fifo_adc_burst_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  almost_full_q;
  logic                  burst_ready_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  overflow_q;
  logic [15:0]           drop_count_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_drop;

  // Request qualification against the current registered flags.
  always_comb begin
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    wr_drop   = 1'b0;
    level_nxt = level_q;
    wr_acc    = bus.wr_en & ~full_q;
    rd_acc    = bus.rd_en & ~empty_q;
    wr_drop   = bus.wr_en & full_q;
    if (wr_acc && !rd_acc) begin
      level_nxt = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_nxt = level_q - LW'(1);
    end
  end

  // Sample storage is never cleared; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= bus.adc_data_in;
    end
  end

  // Pointers, occupancy and flags; flags come from the next-state level so
  // they never lag the level they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      burst_ready_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      level_q       <= level_nxt;
      full_q        <= (level_nxt == LW'(FIFO_DEPTH));
      empty_q       <= (level_nxt == '0);
      almost_full_q <= (level_nxt >= LW'(AF_LEVEL));
      burst_ready_q <= (level_nxt >= LW'(BURST_LEN));
    end
  end

  // Read data path: data_out holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= mem[rd_ptr];
    end
  end

  // Overflow tracking; a same-cycle clear takes priority over a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (bus.clr_ovf) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (wr_drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.level       = level_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = almost_full_q;
  assign bus.burst_ready = burst_ready_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_count_q;
endmodule

// File: doc/fifo_adc_burst.md
# fifo_adc_burst

Parametrised synchronous sample FIFO between the ADC capture front-end and the PSRAM write controller. It buffers ADC samples and reports an exact occupancy level. A `burst_ready` flag tells the PSRAM side that a full burst can be drained, and `almost_full` gives back-pressure warning. Samples dropped on overflow are counted and flagged instead of being silently lost.

## Interface
- `DATA_WIDTH`, 16: sample width in bits (12 or 16 used).
- `FIFO_DEPTH`, 128: number of entries; must be a power of two, ≥4.
- `BURST_LEN`, 16: burst size for `burst_ready`; 1 ≤ BURST_LEN ≤ FIFO_DEPTH.
- `AF_LEVEL`, 96: `almost_full` threshold; 1 ≤ AF_LEVEL ≤ FIFO_DEPTH.
- Derived: `AW = $clog2(FIFO_DEPTH)`, `LW = AW+1`.

Ports:
- `clk` input 1: single system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `wr_en` input 1: write request.
- `adc_data_in` input DATA_WIDTH: sample to write.
- `rd_en` input 1: read request.
- `clr_ovf` input 1: clears `overflow` and `drop_count`.
- `data_out` output DATA_WIDTH: read data, registered.
- `data_valid` output 1: one-cycle pulse, `data_out` updated this cycle.
- `level` output LW: current occupancy, 0..FIFO_DEPTH.
- `full` output 1: level == FIFO_DEPTH.
- `empty` output 1: level == 0.
- `almost_full` output 1: level ≥ AF_LEVEL.
- `burst_ready` output 1: level ≥ BURST_LEN.
- `overflow` output 1: sticky; a write was dropped.
- `drop_count` output 16: dropped writes, saturating at 16'hFFFF.

## Operation
- Storage: `FIFO_DEPTH` × `DATA_WIDTH` array. `wr_ptr`/`rd_ptr` are AW bits and wrap naturally from FIFO_DEPTH-1 to 0.
- The occupancy counter `level` is LW bits wide, so FIFO_DEPTH is representable and full is reachable.
- Write accepted: `wr_acc = wr_en & ~full`. The sample is stored at `wr_ptr` and `wr_ptr` increments.
- Write dropped: `wr_en & full`. This sets `overflow`, and `drop_count` increments unless already 16'hFFFF. Array, pointers and level are unchanged.
- Read accepted: `rd_acc = rd_en & ~empty`. `data_out <= mem[rd_ptr]`, `rd_ptr` increments, and `data_valid` = 1 next cycle.
- Read on empty is ignored. `data_valid` = 0 and `data_out` holds.
- Level update:
  - `wr_acc & ~rd_acc`: +1.
  - `rd_acc & ~wr_acc`: −1.
  - Both or neither: unchanged.
- Simultaneous read and write when full: the read is accepted, the write is dropped (full gates it), and level becomes FIFO_DEPTH−1.
- Simultaneous read and write when empty: the write is accepted, the read is ignored, and level becomes 1.
- Simultaneous read and write otherwise: both are accepted and level is unchanged.
- Status flags are registered from the next-state level. They always agree with `level` in the same cycle, with no one-cycle lag.
- `clr_ovf`: `overflow <= 0` and `drop_count <= 0`. If a drop happens in the same cycle, the clear wins and that drop is not counted.
- `data_out` holds its last value until the next accepted read.

## Timing
- Reset values (one clock with `reset` = 1):
  - Pointers and level = 0.
  - `data_out` = 0, `data_valid` = 0.
  - `empty` = 1.
  - `full`, `almost_full`, `burst_ready` = 0.
  - `overflow` = 0, `drop_count` = 0.
  - Memory contents are not cleared.
- Reset mid-operation: reset overrides all same-cycle `wr_en`/`rd_en`/`clr_ovf`. Any stored data is discarded.
- Write-to-flag latency: with a write accepted at edge N, `level`/`empty`/`burst_ready` reflect it after edge N.
- Write-to-read latency: the earliest read of that sample is `rd_en` in cycle N+1, giving `data_valid` after edge N+1.
- Read latency: 1 cycle from the `rd_en` edge to `data_out`/`data_valid`.
- Sustained throughput: 1 write and 1 read per cycle.

## Test plan
- Reset, then write 5 samples 0x0001..0x0005, then hold `rd_en` for 6 cycles:
  - Expect `data_valid` pulses with 1,2,3,4,5, then none on the 6th read.
  - Expect `level` stepping 5→0 and `empty` = 1 after the 5th read.
- Write 128 samples with default parameters:
  - `burst_ready` rises exactly when level = 16.
  - `almost_full` rises at level = 96.
  - `full` rises at level = 128.
  - A 129th and 130th write give `overflow` = 1 and `drop_count` = 2, with level staying 128.
- At level = 128, assert `wr_en` and `rd_en` together: level = 127, and the oldest sample is output.
  - Next cycle repeat: level stays 127 and the write is stored.
- Wrap-around: run 300 cycles of simultaneous write/read of an incrementing pattern at level 3.
  - Output sequence is exact and contiguous, with pointers wrapping twice.
- Assert `reset` during streaming at level 40: the next cycle shows level 0, `empty` = 1, `data_valid` = 0.
  - `overflow` and `drop_count` are cleared.
- Drive `drop_count` to 16'hFFFF (forced or long run) with an extra dropped write: it stays at FFFF.
  - `clr_ovf` in the same cycle as a drop gives `drop_count` = 0 and `overflow` = 0.
